uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
//   8-bit UART transmitter. Serialises bytes as 8N1 frames: start bit, 8 data bits LSB-first, stop bit.
//   An optional parity bit is inserted before the stop bit.
//   Sits beside the UART receive path and is fed by the CPU/MMIO side over a valid/ready handshake.
//   It derives its own bit timing from clk. It has no dependency on the receive-side oversampling clock.
//
// PARAMETERS
//   CLKS_PER_BIT  208  clk cycles per serial bit (24 MHz / 115200 ~= 208); must be >= 2
//   PARITY_ODD    0    0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined
//
// PORTS
//   clk       in   1  system clock, single clock domain
//   reset_n   in   1  reset, asynchronous assert, active-low
//   tx_data   in   8  byte to send; sampled only on the handshake cycle
//   tx_valid  in   1  producer has a byte on tx_data
//   tx_ready  out  1  transmitter can accept a byte; high only in IDLE
//   tx        out  1  serial line; idles high
//   busy      out  1  high from the cycle after the handshake until the frame completes
//
// BEHAVIOUR
//   Reset values
//   - tx=1, tx_ready=1, busy=0.
//   - State=IDLE; bit counter, cycle counter and shift register all 0.
//   - Reset mid-frame aborts the frame at once: tx returns to 1 asynchronously and no partial byte resumes.
//   Handshake
//   - Transfer occurs when tx_valid & tx_ready at a posedge clk.
//   - tx_data is latched into the shift register on that edge; later changes to tx_data are ignored.
//   - tx_valid without tx_ready has no effect; the producer must hold it until the handshake.
//   States
//   - IDLE:   tx=1. On handshake go to START and clear the cycle counter.
//   - START:  tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//   - DATA:   tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index.
//             After index 7 completes go to PARITY if enabled, otherwise STOP.
//   - PARITY: tx = ^byte ^ PARITY_ODD for CLKS_PER_BIT cycles, then go to STOP.
//   - STOP:   tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
//   Timing
//   - tx is registered. The start bit appears on tx the cycle after the handshake (latency 1).
//   - Every bit lasts exactly CLKS_PER_BIT cycles.
//   - Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
//   - tx_ready rises in the first IDLE cycle after the stop bit ends.
//   - With tx_valid held high, the minimum line-high time between frames is CLKS_PER_BIT+1 cycles:
//     the stop bit plus one IDLE cycle.
//   Counters
//   - Cycle counter is $clog2(CLKS_PER_BIT) bits wide. It wraps to 0 on reaching CLKS_PER_BIT-1,
//     and the state/bit advances on that same cycle.
//   - Bit index is 3 bits wide and does not wrap inside a frame.
//   Boundary cases
//   - A handshake cannot occur outside IDLE.
//   - tx_valid deasserting mid-frame has no effect.
//   - tx_data=0x00 and tx_data=0xFF need no special handling.
//
// CONFIGURATION
//   UART_PARITY_EN defined
//   - PARITY state is present. The frame is 11 bits and the parity bit follows PARITY_ODD.
//   UART_PARITY_EN undefined
//   - PARITY state and parity logic are compiled out. The frame is 8N1 (10 bits).
//   - PARITY_ODD is accepted and ignored.
//
// STRUCTURE
//   Shared package uart_pkg
//   - UART_DATA_BITS=8 and UART_CLKS_PER_BIT_DEFAULT=208.
//   - typedef enum logic [2:0] uart_tx_state_e {IDLE, START, DATA, PARITY, STOP}.
//   - The receive side reuses UART_DATA_BITS.
//   Sub-module uart_tx_baud
//   - Bit-period counter with a synchronous clear input and a one-cycle bit_done pulse output.
//   - uart_tx contains the FSM, shift register and output register.
//
// TESTING (bench uses CLKS_PER_BIT=4)
//   1. Reset only: tx=1, tx_ready=1 and busy=0 during and after reset, held for 20 cycles.
//   2. Send 0xA5 (macro undefined):
//      - tx line reads 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles.
//      - tx_ready is low for 40 cycles.
//   3. Back-to-back 0x00 then 0xFF with tx_valid held high:
//      - second start bit begins 5 cycles after the first stop bit begins.
//      - exactly 2 handshakes occur.
//   4. Change tx_data from 0x3C to 0xC3 one cycle after the handshake: serialised byte is 0x3C.
//   5. Assert reset_n=0 during data bit 3 of 0x55:
//      - tx=1 immediately, state returns to IDLE.
//      - after release tx_ready=1 and no residual bits appear.
//   6. UART_PARITY_EN defined:
//      - 0xA5 with PARITY_ODD=0 gives parity bit 0; with PARITY_ODD=1 it gives 1.
//      - 0x07 with PARITY_ODD=0 gives parity bit 1.
//      - each frame lasts 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receive path.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period counter for the UART transmitter.
// It emits a one-cycle bit_done_o pulse on the last cycle of each serial bit.
module uart_tx_baud #(
  parameter int CLKS_PER_BIT = 208
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  output logic bit_done_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // The state advances on the same cycle that the counter wraps.
  assign bit_done_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB-first, stop bit.
// Define UART_PARITY_EN to insert a parity bit (polarity set by PARITY_ODD) before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_e            state_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_q;
  logic                      ready_q;
  logic                      busy_q;
  logic                      bit_done;
  logic                      handshake;
`ifdef UART_PARITY_EN
  logic                      par_q;
`endif

  assign handshake = tx_valid && ready_q;

  // The counter is held cleared in IDLE so each frame starts on a fresh bit period.
  uart_tx_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (state_q == IDLE),
    .bit_done_o (bit_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            state_q <= START;
            shift_q <= tx_data;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef UART_PARITY_EN
            // Parity is taken from the byte here because the shift register is consumed.
            par_q   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= shift_q >> 1;
            if (bit_q == LAST_BIT) begin
              bit_q   <= '0;
`ifdef UART_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4; follows UART_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready0, tx0, busy0;
  logic       tx_ready1, tx1, busy1;

  int checks = 0;
  int passed = 0;
  int hs     = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready0), .tx(tx0), .busy(busy0));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready1), .tx(tx1), .busy(busy1));

  always @(posedge clk) if (reset_n && tx_valid && tx_ready0) hs++;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a frame is a list of line levels, one per bit, start bit first.
  function automatic logic par_of(input logic [7:0] b, input int odd);
    return logic'(($countones(b) + odd) % 2);
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic par);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_PARITY_EN
    f[9] = par;
`else
    f[9] = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [127:0] wave_of(input logic [10:0] f);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < FL; k++) w[k] = f[k / CPB];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Handshake one byte then record both lines for a whole frame.
  // mode 0: quiet inputs, 1: invert tx_data right after the handshake, 2: random inputs mid-frame.
  task automatic run_frame(input logic [7:0] b, input int mode,
                           output logic [127:0] w0, output logic [127:0] w1,
                           output int rdy_low, output int busy_hi, output logic [2:0] idle_st);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    w0 = '0; w1 = '0; rdy_low = 0; busy_hi = 0;
    for (int k = 0; k < FL; k++) begin
      w0[k] = tx0;
      w1[k] = tx1;
      if (!tx_ready0) rdy_low++;
      if (busy0) busy_hi++;
      if (mode == 1 && k == 0) tx_data = ~b;
      if (mode == 2) begin
        tx_data  = 8'($urandom);
        tx_valid = 1'($urandom);
      end
      tick();
    end
    tx_valid = 1'b0;
    idle_st  = {tx0, tx_ready0, busy0};
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line8n1;   // expected 8N1 line, first bit in bit 0
    logic       par_even;
  } vec_t;

  vec_t         tbl[6];
  logic [127:0] w0, w1, tr, exp_tr;
  logic [10:0]  f;
  int           rl, bh, hs0, bad, gap;
  logic [2:0]   ist;
  string        nm;

  initial begin
    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[3] = '{8'h3C, 10'b1001111000, 1'b0};
    tbl[4] = '{8'h07, 10'b1000001110, 1'b1};
    tbl[5] = '{8'h55, 10'b1010101010, 1'b0};

    // Reset held for 20 cycles, then 20 idle cycles.
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ({tx0, tx_ready0, busy0, tx1, tx_ready1, busy1} !== 6'b110110) bad++;
    end
    check("reset_hold", 128'(bad), 128'd0);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ({tx0, tx_ready0, busy0} !== 3'b110) bad++;
    end
    check("post_reset_idle", 128'(bad), 128'd0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].data, 0, w0, w1, rl, bh, ist);
      f = {1'b1, tbl[i].par_even, tbl[i].line8n1[8:0]};
`ifndef UART_PARITY_EN
      f = {1'b1, tbl[i].line8n1};
`endif
      nm = $sformatf("line0_%h", tbl[i].data);
      check(nm, w0, wave_of(f));
`ifdef UART_PARITY_EN
      f[9] = ~tbl[i].par_even;
`endif
      nm = $sformatf("line1_%h", tbl[i].data);
      check(nm, w1, wave_of(f));
      nm = $sformatf("ready_low_%h", tbl[i].data);
      check(nm, 128'(rl), 128'(FL));
      nm = $sformatf("busy_high_%h", tbl[i].data);
      check(nm, 128'(bh), 128'(FL));
      nm = $sformatf("idle_after_%h", tbl[i].data);
      check(nm, 128'(ist), 128'(3'b110));
      for (int k = 0; k < 3; k++) tick();
    end

`ifdef UART_PARITY_EN
    run_frame(8'hA5, 0, w0, w1, rl, bh, ist);
    check("parity_a5_even", 128'(w0[9*CPB + 1]), 128'(1'b0));
    check("parity_a5_odd",  128'(w1[9*CPB + 1]), 128'(1'b1));
    run_frame(8'h07, 0, w0, w1, rl, bh, ist);
    check("parity_07_even", 128'(w0[9*CPB + 1]), 128'(1'b1));
    check("frame_len_44",   128'(rl), 128'd44);
    tick();
`endif

    // tx_data changes one cycle after the handshake: the latched byte is sent.
    run_frame(8'h3C, 1, w0, w1, rl, bh, ist);
    check("data_latched_3c", w0, wave_of(frame_of(8'h3C, par_of(8'h3C, 0))));
    tick();

    // Back-to-back 0x00 then 0xFF with tx_valid held high.
    hs0 = hs;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    tr = '0;
    for (int k = 0; k < 2*FL + 1; k++) begin
      tr[k] = tx0;
      tick();
      if (k == FL) tx_valid = 1'b0;
    end
    exp_tr = wave_of(frame_of(8'h00, par_of(8'h00, 0)));
    exp_tr[FL] = 1'b1;
    exp_tr = exp_tr | (wave_of(frame_of(8'hFF, par_of(8'hFF, 0))) << (FL + 1));
    check("b2b_line", tr, exp_tr);
    gap = -1;
    for (int k = (NB-1)*CPB; k < 2*FL + 1; k++)
      if (gap < 0 && tr[k] == 1'b0) gap = k - (NB-1)*CPB;
    check("b2b_gap", 128'(gap), 128'(CPB + 1));
    for (int k = 0; k < 4; k++) tick();
    check("b2b_handshakes", 128'(hs - hs0), 128'd2);

    // Reset during data bit 3 of 0x55.
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 4*CPB + 1; k++) tick();
    check("pre_reset_bit3", 128'(tx0), 128'(1'b0));
    reset_n = 1'b0;
    #1;
    check("async_reset_out", 128'({tx0, tx_ready0, busy0, tx1}), 128'(4'b1101));
    tick();
    tick();
    reset_n = 1'b1;
    hs0 = hs;
    bad = 0;
    for (int k = 0; k < FL + 10; k++) begin
      tick();
      if ({tx0, tx_ready0, busy0} !== 3'b110) bad++;
    end
    check("no_residual_bits", 128'(bad), 128'd0);
    check("no_handshake_after_reset", 128'(hs - hs0), 128'd0);

    // Random bytes with random mid-frame input activity and idle gaps.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      hs0 = hs;
      run_frame(rb, 2, w0, w1, rl, bh, ist);
      nm = $sformatf("rand_line0_%h", rb);
      check(nm, w0, wave_of(frame_of(rb, par_of(rb, 0))));
      nm = $sformatf("rand_line1_%h", rb);
      check(nm, w1, wave_of(frame_of(rb, par_of(rb, 1))));
      nm = $sformatf("rand_one_handshake_%h", rb);
      check(nm, 128'({hs - hs0, ist}), 128'({32'd1, 3'b110}));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
